// File: rtl/axil_write_guard.sv
// AXI-Lite write firewall: writes into [PROT_LO, PROT_HI] get SLVERR, all others pass to the master side.
// Latency: both slave handshakes in cycle N -> decision in N+1 -> master valids (or SLVERR) in N+2.
// Backpressure: one write in flight; slave readies stay low until the write response has been accepted.

module axil_write_guard #(
   parameter logic [31:0] PROT_LO = 32'h4000_0000,
   parameter logic [31:0] PROT_HI = 32'h4000_FFFF,
   parameter int          CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   // slave write address
   input  logic             s_awvalid,
   output logic             s_awready,
   input  logic [31:0]      s_awaddr,
   // slave write data
   input  logic             s_wvalid,
   output logic             s_wready,
   input  logic [31:0]      s_wdata,
   input  logic [3:0]       s_wstrb,
   // slave write response
   output logic             s_bvalid,
   input  logic             s_bready,
   output logic [1:0]       s_bresp,
   // master write address
   output logic             m_awvalid,
   input  logic             m_awready,
   output logic [31:0]      m_awaddr,
   // master write data
   output logic             m_wvalid,
   input  logic             m_wready,
   output logic [31:0]      m_wdata,
   output logic [3:0]       m_wstrb,
   // master write response
   input  logic             m_bvalid,
   output logic             m_bready,
   input  logic [1:0]       m_bresp,
   // status
   output logic             violation_pulse,
   output logic [CNT_W-1:0] viol_count,
   output logic [31:0]      viol_addr
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CHECK = 3'd1,
      FWD   = 3'd2,
      BWAIT = 3'd3,
      ERR   = 3'd4
   } state_t;

   localparam logic [1:0] RESP_SLVERR = 2'b10;

   state_t      state;
   logic        aw_held;
   logic        w_held;
   logic        aw_sent;
   logic        w_sent;
   logic [31:0] aw_addr_q;
   logic [31:0] w_data_q;
   logic [3:0]  w_strb_q;

   logic        aw_fire;
   logic        w_fire;
   logic        maw_fire;
   logic        mw_fire;
   logic        blocked;

   // Handshake outputs decode from state; everything is forced low while rst is high.
   assign s_awready = !rst && (state == IDLE) && !aw_held;
   assign s_wready  = !rst && (state == IDLE) && !w_held;
   assign m_awvalid = !rst && (state == FWD) && !aw_sent;
   assign m_wvalid  = !rst && (state == FWD) && !w_sent;
   assign m_bready  = !rst && (state == BWAIT) && s_bready;
   assign s_bvalid  = !rst && (((state == BWAIT) && m_bvalid) || (state == ERR));
   assign s_bresp   = rst            ? 2'b00       :
                      (state == BWAIT) ? m_bresp     :
                      (state == ERR)   ? RESP_SLVERR : 2'b00;

   assign m_awaddr  = aw_addr_q;
   assign m_wdata   = w_data_q;
   assign m_wstrb   = w_strb_q;

   assign aw_fire   = s_awvalid && s_awready;
   assign w_fire    = s_wvalid && s_wready;
   assign maw_fire  = m_awvalid && m_awready;
   assign mw_fire   = m_wvalid && m_wready;
   assign blocked   = (aw_addr_q >= PROT_LO) && (aw_addr_q <= PROT_HI);

   // Transaction FSM: capture both channels, classify the address, forward or reject, return the response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         aw_held         <= 1'b0;
         w_held          <= 1'b0;
         aw_sent         <= 1'b0;
         w_sent          <= 1'b0;
         aw_addr_q       <= '0;
         w_data_q        <= '0;
         w_strb_q        <= '0;
         viol_addr       <= '0;
         viol_count      <= '0;
         violation_pulse <= 1'b0;
      end else begin
         violation_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (aw_fire) begin
                  aw_addr_q <= s_awaddr;
                  aw_held   <= 1'b1;
               end
               if (w_fire) begin
                  w_data_q <= s_wdata;
                  w_strb_q <= s_wstrb;
                  w_held   <= 1'b1;
               end
               if ((aw_held || aw_fire) && (w_held || w_fire)) begin
                  state <= CHECK;
               end
            end
            CHECK: begin
               if (blocked) begin
                  state           <= ERR;
                  violation_pulse <= 1'b1;
                  viol_addr       <= aw_addr_q;
                  if (viol_count != '1) begin
                     viol_count <= viol_count + CNT_W'(1);
                  end
               end else begin
                  state <= FWD;
               end
            end
            FWD: begin
               if (maw_fire) begin
                  aw_sent <= 1'b1;
               end
               if (mw_fire) begin
                  w_sent <= 1'b1;
               end
               if ((aw_sent || maw_fire) && (w_sent || mw_fire)) begin
                  state <= BWAIT;
               end
            end
            BWAIT: begin
               if (m_bvalid && s_bready) begin
                  state   <= IDLE;
                  aw_held <= 1'b0;
                  w_held  <= 1'b0;
                  aw_sent <= 1'b0;
                  w_sent  <= 1'b0;
               end
            end
            ERR: begin
               if (s_bready) begin
                  state   <= IDLE;
                  aw_held <= 1'b0;
                  w_held  <= 1'b0;
                  aw_sent <= 1'b0;
                  w_sent  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axil_write_guard.sv
// Randomized bench for axil_write_guard: a host driver issues writes, a master-side responder answers,
// and negedge monitors compare DUT outputs against queues filled by an address-window reference model.
// A second instance with a 2-bit counter shares all inputs and is used for the saturation checks.

module tb_axil_write_guard;

   localparam logic [31:0] PROT_LO = 32'h4000_0000;
   localparam logic [31:0] PROT_HI = 32'h4000_FFFF;

   logic        clk = 1'b0;
   logic        rst;
   logic        s_awvalid, s_awready;
   logic [31:0] s_awaddr;
   logic        s_wvalid, s_wready;
   logic [31:0] s_wdata;
   logic [3:0]  s_wstrb;
   logic        s_bvalid, s_bready;
   logic [1:0]  s_bresp;
   logic        m_awvalid, m_awready;
   logic [31:0] m_awaddr;
   logic        m_wvalid, m_wready;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_bvalid, m_bready;
   logic [1:0]  m_bresp;
   logic        violation_pulse;
   logic [15:0] viol_count;
   logic [31:0] viol_addr;

   logic        sat_s_awready, sat_s_wready, sat_s_bvalid;
   logic [1:0]  sat_s_bresp;
   logic        sat_m_awvalid, sat_m_wvalid, sat_m_bready;
   logic [31:0] sat_m_awaddr, sat_m_wdata;
   logic [3:0]  sat_m_wstrb;
   logic        sat_violation_pulse;
   logic [1:0]  sat_viol_count;
   logic [31:0] sat_viol_addr;

   axil_write_guard #(.PROT_LO(PROT_LO), .PROT_HI(PROT_HI), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
      .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
      .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
      .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
      .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
      .violation_pulse(violation_pulse), .viol_count(viol_count), .viol_addr(viol_addr)
   );

   axil_write_guard #(.PROT_LO(PROT_LO), .PROT_HI(PROT_HI), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst),
      .s_awvalid(s_awvalid), .s_awready(sat_s_awready), .s_awaddr(s_awaddr),
      .s_wvalid(s_wvalid), .s_wready(sat_s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
      .s_bvalid(sat_s_bvalid), .s_bready(s_bready), .s_bresp(sat_s_bresp),
      .m_awvalid(sat_m_awvalid), .m_awready(m_awready), .m_awaddr(sat_m_awaddr),
      .m_wvalid(sat_m_wvalid), .m_wready(m_wready), .m_wdata(sat_m_wdata), .m_wstrb(sat_m_wstrb),
      .m_bvalid(m_bvalid), .m_bready(sat_m_bready), .m_bresp(m_bresp),
      .violation_pulse(sat_violation_pulse), .viol_count(sat_viol_count), .viol_addr(sat_viol_addr)
   );

   initial forever #5 clk = ~clk;

   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // ---------------- scoreboard state ----------------
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] aw_q[$];
   logic [35:0] w_q[$];
   logic [1:0]  exp_b_q[$];
   logic [1:0]  mb_resp_q[$];
   logic [31:0] viol_addr_q[$];
   int          viol_n_q[$];
   int          nblk = 0;
   bit          lat_armed = 0;
   int          hs_cyc = 0;

   // responder state
   int aw_fwd = 0, w_fwd = 0, b_done = 0, aw_stall = 0;
   bit mb_busy = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic bad(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   function automatic bit in_window(input logic [31:0] a);
      return (a >= PROT_LO) && (a <= PROT_HI);
   endfunction

   // Reference model: a write in the window is rejected and counted, anything else is forwarded
   // and its response is whatever the downstream slave returns.
   task automatic ref_push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st, input bit rnd_resp);
      logic [1:0] r;
      if (in_window(a)) begin
         nblk++;
         exp_b_q.push_back(2'b10);
         viol_addr_q.push_back(a);
         viol_n_q.push_back(nblk);
      end else begin
         r = rnd_resp ? 2'($urandom_range(0, 3)) : 2'b00;
         aw_q.push_back(a);
         w_q.push_back({d, st});
         mb_resp_q.push_back(r);
         exp_b_q.push_back(r);
      end
   endtask

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      int          n;
      logic [31:0] va;
      if (!rst) begin
         if (m_awvalid) begin
            if (aw_q.size() == 0) bad("m_awvalid_unexpected", m_awaddr, 0);
            else begin
               chk("m_awaddr", m_awaddr, aw_q[0]);
               if (m_awready) void'(aw_q.pop_front());
            end
         end
         if (m_wvalid) begin
            if (w_q.size() == 0) bad("m_wvalid_unexpected", {m_wdata, m_wstrb}, 0);
            else begin
               chk("m_wdata_wstrb", {m_wdata, m_wstrb}, w_q[0]);
               if (m_wready) void'(w_q.pop_front());
            end
         end
         if (s_bvalid) begin
            if (exp_b_q.size() == 0) bad("s_bvalid_unexpected", s_bresp, 0);
            else begin
               chk("s_bresp", s_bresp, exp_b_q[0]);
               if (s_bready) void'(exp_b_q.pop_front());
            end
         end
         if (violation_pulse) begin
            if (viol_n_q.size() == 0) bad("violation_pulse_unexpected", viol_addr, 0);
            else begin
               n  = viol_n_q.pop_front();
               va = viol_addr_q.pop_front();
               chk("viol_addr", viol_addr, va);
               chk("viol_count", viol_count, (n > 65535) ? 65535 : n);
               chk("sat_viol_count", sat_viol_count, (n > 3) ? 3 : n);
            end
         end
         if (lat_armed && (m_awvalid || s_bvalid)) begin
            chk("latency", cyc_cnt - hs_cyc, 2);
            lat_armed = 0;
         end
      end
   end

   // ---------------- downstream slave model ----------------
   initial begin
      m_awready = 1'b0;
      m_wready  = 1'b0;
      m_bvalid  = 1'b0;
      m_bresp   = 2'b00;
      forever begin
         @(posedge clk); #1;
         m_awready = (aw_stall > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
         m_wready  = (aw_stall > 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
         if (!mb_busy) begin
            if ((((aw_fwd < w_fwd) ? aw_fwd : w_fwd) > b_done) && (mb_resp_q.size() > 0)
                && ($urandom_range(0, 1) == 1)) begin
               m_bvalid = 1'b1;
               m_bresp  = mb_resp_q.pop_front();
               mb_busy  = 1;
            end else begin
               // stray responses with nothing outstanding must be ignored by the guard
               m_bvalid = ((((aw_fwd < w_fwd) ? aw_fwd : w_fwd) == b_done) && ($urandom_range(0, 7) == 0));
               m_bresp  = 2'($urandom_range(0, 3));
            end
         end
         @(negedge clk);
         if (!rst) begin
            if (m_awvalid && m_awready) aw_fwd++;
            if (m_wvalid && m_wready) w_fwd++;
            if (m_awvalid && aw_stall > 0) aw_stall--;
            if (mb_busy && m_bready) begin
               b_done++;
               mb_busy = 0;
            end
         end
      end
   end

   // ---------------- host driver ----------------
   task automatic send_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                           input int aw_dly, input int w_dly, input bit rnd_resp);
      int c   = 0;
      bit awd = 0;
      bit wd  = 0;
      ref_push(a, d, st, rnd_resp);
      while (!(awd && wd)) begin
         s_awvalid = !awd && (c >= aw_dly);
         s_awaddr  = a;
         s_wvalid  = !wd && (c >= w_dly);
         s_wdata   = d;
         s_wstrb   = st;
         @(negedge clk);
         if (wd)  chk("s_wready_low_after_w", s_wready, 0);
         if (awd) chk("s_awready_low_after_aw", s_awready, 0);
         if (s_awvalid && s_awready) awd = 1;
         if (s_wvalid && s_wready) wd = 1;
         if (awd && wd) begin
            hs_cyc    = cyc_cnt;
            lat_armed = 1;
         end
         @(posedge clk); #1;
         c++;
         if (c > 200) begin
            bad("slave_handshake_timeout", {awd, wd}, 2'b11);
            break;
         end
      end
      s_awvalid = 1'b0;
      s_wvalid  = 1'b0;
   endtask

   task automatic get_resp(input int bhold);
      int c    = 0;
      int seen = 0;
      bit done = 0;
      while (!done) begin
         s_bready = (seen >= bhold) ? ($urandom_range(0, 2) != 0) : 1'b0;
         @(negedge clk);
         chk("slave_ready_low_busy", {s_awready, s_wready}, 0);
         if (s_bvalid) seen++;
         if (s_bvalid && s_bready) done = 1;
         @(posedge clk); #1;
         c++;
         if (!done && c > 300) begin
            bad("response_timeout", seen, 1);
            break;
         end
      end
      s_bready = 1'b0;
      @(negedge clk);
      chk("ready_first_idle", {s_awready, s_wready}, 2'b11);
      @(posedge clk); #1;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                           input int aw_dly, input int w_dly, input int bhold, input bit rnd_resp);
      send_req(a, d, st, aw_dly, w_dly, rnd_resp);
      get_resp(bhold);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] a;
      rst = 1'b1;
      s_awvalid = 1'b0; s_awaddr = '0;
      s_wvalid = 1'b0; s_wdata = '0; s_wstrb = '0;
      s_bready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_handshakes", {s_awready, s_wready, m_awvalid, m_wvalid, m_bready, s_bvalid}, 0);
      chk("rst_status", {violation_pulse, viol_count, viol_addr}, 0);
      chk("rst_bresp", s_bresp, 0);
      chk("rst_payload", {m_awaddr, m_wdata}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("first_cycle_ready", {s_awready, s_wready}, 2'b11);
      @(posedge clk); #1;

      // allowed write just below the window, both channels together
      do_write(32'h3FFF_FFFC, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0);
      chk("count_after_allowed", viol_count, 0);

      // both inclusive window edges are rejected
      do_write(PROT_LO, 32'h1111_2222, 4'hF, 0, 0, 0, 0);
      do_write(PROT_HI, 32'h3333_4444, 4'hF, 0, 0, 0, 0);
      chk("count_two_blocked", viol_count, 2);
      chk("addr_last_blocked", viol_addr, 32'h4000_FFFF);

      // first address past the window is forwarded
      do_write(32'h4001_0000, 32'h5555_6666, 4'hF, 0, 0, 0, 0);
      chk("count_after_upper_edge", viol_count, 2);

      // channel ordering: W early, then AW early
      do_write(32'h1000_0010, 32'hA5A5_0F0F, 4'b0101, 3, 0, 0, 0);
      do_write(32'h2000_0020, 32'h1234_5678, 4'b0101, 0, 3, 0, 0);

      // master AW backpressure, then held SLVERR
      aw_stall = 5;
      do_write(32'h0000_1000, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 0);
      do_write(PROT_LO + 32'h100, 32'h0BAD_0BAD, 4'hF, 0, 0, 4, 0);

      // saturation of the narrow counter
      repeat (5) do_write(PROT_LO + ($urandom & 32'h0000_FFFC), $urandom, 4'hF, 0, 0, 0, 0);
      chk("sat_count_saturated", sat_viol_count, 3);
      chk("wide_count_after_sat", viol_count, 8);

      // reset while the write sits in FWD
      aw_stall = 1000;
      send_req(32'h0000_2000, 32'h7777_8888, 4'hF, 0, 0, 0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (m_awvalid) break;
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      rst = 1'b1;
      aw_q.delete(); w_q.delete(); exp_b_q.delete(); mb_resp_q.delete();
      viol_addr_q.delete(); viol_n_q.delete();
      nblk = 0; lat_armed = 0;
      aw_fwd = 0; w_fwd = 0; b_done = 0; mb_busy = 0; aw_stall = 0;
      @(negedge clk);
      chk("mid_rst_handshakes", {s_awready, s_wready, m_awvalid, m_wvalid, m_bready, s_bvalid}, 0);
      chk("mid_rst_bresp", s_bresp, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", {s_awready, s_wready}, 2'b11);
      chk("post_rst_valids", {m_awvalid, m_wvalid, m_bready, s_bvalid}, 0);
      chk("post_rst_status", {violation_pulse, viol_count, viol_addr}, 0);
      chk("post_rst_sat_count", sat_viol_count, 0);
      chk("post_rst_payload", {m_awaddr, m_wdata}, 0);
      repeat (10) @(posedge clk);
      #1;

      // randomized traffic concentrated around the window edges
      for (int k = 0; k < 120; k++) begin
         case ($urandom_range(0, 4))
            0:       a = $urandom;
            1:       a = PROT_LO + 32'($urandom_range(0, 32'hFFFF));
            2:       a = PROT_LO - 32'($urandom_range(1, 4));
            3:       a = PROT_HI + 32'($urandom_range(1, 4));
            default: a = PROT_HI - 32'($urandom_range(0, 4));
         endcase
         do_write(a, $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 1);
      end

      repeat (5) @(posedge clk);
      #1;
      @(negedge clk);
      chk("aw_q_drained", aw_q.size(), 0);
      chk("w_q_drained", w_q.size(), 0);
      chk("b_q_drained", exp_b_q.size(), 0);
      chk("viol_q_drained", viol_n_q.size(), 0);
      chk("final_viol_count", viol_count, nblk);
      chk("final_sat_count", sat_viol_count, (nblk > 3) ? 3 : nblk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      n_bad++;
      $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc_cnt);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/axil_write_guard.md
AXIL_WRITE_GUARD -- requirements
Module: axil_write_guard

Interface
REQ-001 SHALL have parameter PROT_LO, default 32'h4000_0000: lowest protected byte address, inclusive.
REQ-002 SHALL have parameter PROT_HI, default 32'h4000_FFFF: highest protected byte address, inclusive.
REQ-003 SHALL have parameter CNT_W, default 16: width of the violation counter.
REQ-004 SHALL have one clock and a synchronous, active-high reset:
- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have the slave write-address port:
- s_awvalid  in  1
- s_awready  out  1
- s_awaddr  in  32
REQ-006 SHALL have the slave write-data port:
- s_wvalid  in  1
- s_wready  out  1
- s_wdata  in  32
- s_wstrb  in  4
REQ-007 SHALL have the slave write-response port:
- s_bvalid  out  1
- s_bready  in  1
- s_bresp  out  2
REQ-008 SHALL have master ports that mirror REQ-005 to REQ-007 with opposite directions:
- m_awvalid/m_awready/m_awaddr
- m_wvalid/m_wready/m_wdata/m_wstrb
- m_bvalid/m_bready/m_bresp
REQ-009 SHALL have the status outputs:
- violation_pulse  out  1  one-cycle strobe per blocked write.
- viol_count  out  CNT_W  saturating count of blocked writes.
- viol_addr  out  32  address of the most recent blocked write.

Function
REQ-010 SHALL process one write at a time using FSM states IDLE, CHECK, FWD, BWAIT and ERR.
REQ-011 In IDLE, the slave handshakes SHALL be: s_awready = !aw_held and s_wready = !w_held; each handshake registers its payload and sets its held flag.
- AW and W may complete in either order or in the same cycle.
REQ-012 In IDLE, the block SHALL go to CHECK on the edge where both held flags are set (including both handshakes in the same cycle).
REQ-013 CHECK SHALL last exactly one cycle; block = (aw_addr_q >= PROT_LO) && (aw_addr_q <= PROT_HI), unsigned compare; next state is ERR if block, else FWD.
REQ-014 In FWD, the block SHALL drive:
- m_awvalid = !aw_sent and m_wvalid = !w_sent, with registered addr/data/strb held stable while valid.
- Each master handshake sets its sent flag; the two channels complete independently.
- Go to BWAIT once both flags are set.
REQ-015 In BWAIT, the response path SHALL pass straight through combinationally:
- s_bvalid = m_bvalid, s_bresp = m_bresp, m_bready = s_bready.
- Go to IDLE on m_bvalid && s_bready.
REQ-016 In ERR, the block SHALL drive s_bvalid = 1 and s_bresp = 2'b10 (SLVERR), hold both until s_bready, then go to IDLE; a blocked write SHALL never assert m_awvalid or m_wvalid.
REQ-017 On the CHECK-to-ERR edge, the block SHALL:
- Set violation_pulse for exactly the first ERR cycle.
- Load viol_addr <= aw_addr_q.
- Increment viol_count, saturating at all-ones (no wrap).
REQ-018 Outside the owning state, handshake outputs SHALL be 0:
- s_awready/s_wready outside IDLE.
- m_awvalid/m_wvalid outside FWD.
- m_bready outside BWAIT.
- s_bvalid outside BWAIT/ERR.
REQ-019 On return to IDLE, the held/sent flags SHALL clear; s_awready/s_wready rise in the first IDLE cycle.
REQ-020 Latency SHALL be: both slave handshakes complete in cycle N -> CHECK in N+1 -> m_awvalid=1 (or s_bvalid=1 for a blocked write) in N+2.
REQ-021 m_bvalid SHALL be ignored outside BWAIT, and s_bvalid SHALL never be asserted without a matching accepted write.

Reset
REQ-022 While rst=1 at a rising edge, the block SHALL return to the reset state:
- State IDLE; held/sent flags cleared.
- Payload registers and viol_addr = 0; viol_count = 0; violation_pulse = 0.
REQ-023 During and after reset, all valid/ready outputs SHALL be 0, except that s_awready and s_wready SHALL be 1 in the first cycle after rst deasserts; s_bresp and m_bresp-driven outputs SHALL be 2'b00.
REQ-024 Reset asserted mid-transaction (any state) SHALL abandon the write with no response issued; the status outputs clear.

Verification
REQ-025 The bench SHALL cover allowed write: AW 0x3FFF_FFFC with W 0xDEAD_BEEF in the same cycle N -> m_awvalid=1 with m_awaddr=0x3FFF_FFFC and m_wdata=0xDEAD_BEEF in N+2; m_bresp=00 is passed to s_bresp; viol_count stays 0.
REQ-026 The bench SHALL cover blocked boundaries: AW 0x4000_0000, then AW 0x4000_FFFF -> each gets s_bresp=10 and no m_awvalid; violation_pulse fires twice; viol_count=2; viol_addr=0x4000_FFFF.
REQ-027 The bench SHALL cover the upper edge: AW 0x4001_0000 -> forwarded, OKAY response.
REQ-028 The bench SHALL cover channel order: W 3 cycles before AW, and separately AW before W -> a single forward with correct data/strb 4'b0101; s_wready stays 0 after the W handshake until IDLE is re-entered.
REQ-029 The bench SHALL cover backpressure: m_awready=0 for 5 cycles with m_wready=1 -> m_awaddr stable and m_wvalid drops after 1 cycle; s_bready=0 for 4 cycles in ERR -> s_bvalid/s_bresp held.
REQ-030 The bench SHALL cover saturation and reset: CNT_W=2 with 5 blocked writes -> viol_count=3; rst pulsed in FWD -> outputs return to the REQ-022 values next cycle and no response is issued.
